// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - shift-add 32x32 multiply sequencer driving an external 33-bit adder
// Optional feature macro: MULT_SKIP_ADD_EN (fold the shift into ADD when B[0]=0).
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     S,
    input  logic                 x,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     Switches,
    output logic                 sub,
    output logic                 outputEnable,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic             xr_q;
    logic [CW-1:0]    cnt_q;

    wire last_iter = (cnt_q == CNT_LAST);

    assign A        = a_q;
    assign Switches = m_q;
    assign product  = {a_q, b_q};

    // State register; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection; start is only looked at in IDLE so a busy unit cannot be restarted.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ADD;
                end
            end
            ADD: begin
`ifdef MULT_SKIP_ADD_EN
                if (b_q[0]) begin
                    state_next = SHIFT;
                end else begin
                    state_next = last_iter ? DONE : ADD;
                end
`else
                state_next = SHIFT;
`endif
            end
            SHIFT: begin
                state_next = last_iter ? DONE : ADD;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control outputs; the adder is enabled only for an ADD with a set multiplier bit.
    always_comb begin
        sub          = 1'b0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        outputEnable = (state == ADD) && b_q[0];
    end

    // Datapath registers: load on accepted start, accumulate in ADD, shift {xr,A,B} right in SHIFT.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            xr_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_q   <= multiplicand;
                        b_q   <= multiplier;
                        a_q   <= '0;
                        xr_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                ADD: begin
                    if (b_q[0]) begin
                        // Adder carry is only trusted while it is enabled.
                        a_q  <= S;
                        xr_q <= x;
                    end else begin
`ifdef MULT_SKIP_ADD_EN
                        // No add happened, so xr is 0 and the shift can be done right away.
                        a_q   <= {1'b0, a_q[WIDTH-1:1]};
                        b_q   <= {a_q[0], b_q[WIDTH-1:1]};
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                SHIFT: begin
                    a_q   <= {xr_q, a_q[WIDTH-1:1]};
                    b_q   <= {a_q[0], b_q[WIDTH-1:1]};
                    xr_q  <= 1'b0;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
